rot_trng_cond: RTL and testbench

- Entropy conditioning and health-test stage between the ring-oscillator sampler and the RoT TRNG register.
- Takes synchronized raw oscillator bits and runs continuous repetition-count (RCT) and adaptive-proportion (APT) health tests on the raw stream.
- Von Neumann debiases the stream and assembles WIDTH-bit random words.
- Driven by the RoT FSM: gen_i from OP_TRNG_GEN, clear_i from OP_TRNG_CLEAR. Results are consumed through a valid/ack handshake.

---
 rtl/rot_trng_pkg.sv | 17 +
 rtl/rot_trng_health.sv | 69 ++++++
 rtl/rot_trng_cond.sv | 157 +++++++++++++++
 tb/tb_rot_trng_cond.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rot_trng_pkg.sv
// Shared state encoding and default health-test thresholds for the TRNG conditioner.
package rot_trng_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2,
    FAIL    = 2'd3
  } state_e;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_RCT_CUTOFF = 32;
  localparam int DEF_APT_WIN    = 64;
  localparam int DEF_APT_LO     = 24;
  localparam int DEF_APT_HI     = 40;

endpackage

// File: rtl/rot_trng_health.sv
// Continuous repetition-count and adaptive-proportion tests on the raw oscillator stream.
module rot_trng_health
  import rot_trng_pkg::*;
#(
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
  parameter int APT_WIN    = DEF_APT_WIN,
  parameter int APT_LO     = DEF_APT_LO,
  parameter int APT_HI     = DEF_APT_HI
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_bit_i,
  input  logic raw_valid_i,
  input  logic restart_i,
  output logic fail_o
);

  localparam int RW = $clog2(RCT_CUTOFF) + 1;
  localparam int AW = $clog2(APT_WIN) + 1;

  logic [RW-1:0] rct_cnt_q, rct_cnt_d, rct_inc;
  logic          prev_q, prev_d;
  logic [AW-1:0] apt_n_q, apt_n_d, apt_n_inc;
  logic [AW-1:0] apt_ones_q, apt_ones_d, apt_ones_inc;
  logic          rct_fail, apt_fail, apt_end;

  always_comb begin
    // A zero count means no bit seen since restart, so the next bit starts a run of one.
    rct_inc      = (rct_cnt_q != '0 && raw_bit_i == prev_q) ? rct_cnt_q + 1'b1 : RW'(1);
    apt_n_inc    = apt_n_q + 1'b1;
    apt_ones_inc = apt_ones_q + AW'(raw_bit_i);
    apt_end      = (apt_n_inc == AW'(APT_WIN));
    rct_fail     = raw_valid_i && (rct_inc == RW'(RCT_CUTOFF));
    apt_fail     = raw_valid_i && apt_end &&
                   ((apt_ones_inc < AW'(APT_LO)) || (apt_ones_inc > AW'(APT_HI)));
    fail_o       = !restart_i && (rct_fail || apt_fail);

    rct_cnt_d  = rct_cnt_q;
    prev_d     = prev_q;
    apt_n_d    = apt_n_q;
    apt_ones_d = apt_ones_q;
    if (restart_i) begin
      rct_cnt_d  = '0;
      prev_d     = 1'b0;
      apt_n_d    = '0;
      apt_ones_d = '0;
    end else if (raw_valid_i) begin
      rct_cnt_d  = rct_inc;
      prev_d     = raw_bit_i;
      apt_n_d    = apt_end ? '0 : apt_n_inc;
      apt_ones_d = apt_end ? '0 : apt_ones_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rct_cnt_q  <= '0;
      prev_q     <= 1'b0;
      apt_n_q    <= '0;
      apt_ones_q <= '0;
    end else begin
      rct_cnt_q  <= rct_cnt_d;
      prev_q     <= prev_d;
      apt_n_q    <= apt_n_d;
      apt_ones_q <= apt_ones_d;
    end
  end

endmodule

// File: rtl/rot_trng_cond.sv
// TRNG conditioning stage: health tests, Von Neumann debiasing and word assembly
// behind a gen/clear control interface and a valid/ack result handshake.
module rot_trng_cond
  import rot_trng_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
  parameter int APT_WIN    = DEF_APT_WIN,
  parameter int APT_LO     = DEF_APT_LO,
  parameter int APT_HI     = DEF_APT_HI
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             raw_bit_i,
  input  logic             raw_valid_i,
  input  logic             gen_i,
  input  logic             clear_i,
  input  logic             rd_ack_i,
  output logic [WIDTH-1:0] rnd_o,
  output logic             rnd_valid_o,
  output logic             busy_o,
  output logic             health_fail_o
);

  localparam int BW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d, shift_in;
  logic [WIDTH-1:0] rnd_q, rnd_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d, bit_cnt_inc;
  logic             pair_full_q, pair_full_d, pair_b0_q, pair_b0_d;
  logic             rnd_valid_q, rnd_valid_d, busy_q, busy_d, fail_q, fail_d;
  logic             start, h_valid, h_restart, h_fail;

  assign start     = (state_q == IDLE) && gen_i && !clear_i;
  assign h_valid   = raw_valid_i && (state_q == COLLECT) && !clear_i;
  assign h_restart = clear_i || start;

  rot_trng_health #(
    .RCT_CUTOFF(RCT_CUTOFF),
    .APT_WIN   (APT_WIN),
    .APT_LO    (APT_LO),
    .APT_HI    (APT_HI)
  ) u_health (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_bit_i  (raw_bit_i),
    .raw_valid_i(h_valid),
    .restart_i  (h_restart),
    .fail_o     (h_fail)
  );

  always_comb begin
    shift_in    = {shift_q[WIDTH-2:0], pair_b0_q};
    bit_cnt_inc = bit_cnt_q + 1'b1;

    state_d     = state_q;
    shift_d     = shift_q;
    rnd_d       = rnd_q;
    bit_cnt_d   = bit_cnt_q;
    pair_full_d = pair_full_q;
    pair_b0_d   = pair_b0_q;
    rnd_valid_d = rnd_valid_q;
    busy_d      = busy_q;
    fail_d      = fail_q;

    if (clear_i) begin
      state_d     = IDLE;
      shift_d     = '0;
      rnd_d       = '0;
      bit_cnt_d   = '0;
      pair_full_d = 1'b0;
      pair_b0_d   = 1'b0;
      rnd_valid_d = 1'b0;
      busy_d      = 1'b0;
      fail_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gen_i) begin
            state_d     = COLLECT;
            shift_d     = '0;
            bit_cnt_d   = '0;
            pair_full_d = 1'b0;
            pair_b0_d   = 1'b0;
            busy_d      = 1'b1;
          end
        end
        COLLECT: begin
          if (raw_valid_i) begin
            // A health failure on this bit wins over any word it would complete.
            if (h_fail) begin
              state_d     = FAIL;
              shift_d     = '0;
              rnd_d       = '0;
              rnd_valid_d = 1'b0;
              busy_d      = 1'b0;
              fail_d      = 1'b1;
            end else if (!pair_full_q) begin
              pair_full_d = 1'b1;
              pair_b0_d   = raw_bit_i;
            end else begin
              pair_full_d = 1'b0;
              if (pair_b0_q != raw_bit_i) begin
                shift_d   = shift_in;
                bit_cnt_d = bit_cnt_inc;
                if (bit_cnt_inc == BW'(WIDTH)) begin
                  state_d     = DONE;
                  rnd_d       = shift_in;
                  rnd_valid_d = 1'b1;
                  busy_d      = 1'b0;
                end
              end
            end
          end
        end
        DONE: begin
          if (rd_ack_i) begin
            state_d     = IDLE;
            rnd_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      rnd_q       <= '0;
      bit_cnt_q   <= '0;
      pair_full_q <= 1'b0;
      pair_b0_q   <= 1'b0;
      rnd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      rnd_q       <= rnd_d;
      bit_cnt_q   <= bit_cnt_d;
      pair_full_q <= pair_full_d;
      pair_b0_q   <= pair_b0_d;
      rnd_valid_q <= rnd_valid_d;
      busy_q      <= busy_d;
      fail_q      <= fail_d;
    end
  end

  assign rnd_o         = rnd_q;
  assign rnd_valid_o   = rnd_valid_q;
  assign busy_o        = busy_q;
  assign health_fail_o = fail_q;

endmodule

// File: tb/tb_rot_trng_cond.sv
// Directed bench for rot_trng_cond: debiasing results, health failures, clear, ignored inputs, reset.
module tb_rot_trng_cond;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        raw_bit = 1'b0;
  logic        raw_valid = 1'b0;
  logic        gen = 1'b0;
  logic        clr = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] rnd;
  logic        rnd_valid, busy, hfail;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rot_trng_cond dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .raw_bit_i    (raw_bit),
    .raw_valid_i  (raw_valid),
    .gen_i        (gen),
    .clear_i      (clr),
    .rd_ack_i     (ack),
    .rnd_o        (rnd),
    .rnd_valid_o  (rnd_valid),
    .busy_o       (busy),
    .health_fail_o(hfail)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  // Sends pat[n-1:0] MSB first on consecutive cycles; returns one cycle after the last bit.
  task automatic feed(input logic [63:0] pat, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      raw_valid = 1'b1;
      raw_bit   = pat[i];
    end
    @(negedge clk);
    raw_valid = 1'b0;
    raw_bit   = 1'b0;
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0: gen = 1'b1;
      1: clr = 1'b1;
      2: ack = 1'b1;
      default: begin gen = 1'b1; clr = 1'b1; end
    endcase
    @(negedge clk);
    gen = 1'b0;
    clr = 1'b0;
    ack = 1'b0;
  endtask

  localparam logic [63:0] P10   = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] P01   = 64'h5555_5555_5555_5555;
  localparam logic [63:0] P1001 = 64'h9999_9999_9999_9999;
  localparam logic [63:0] P1110 = 64'hEEEE_EEEE_EEEE_EEEE;
  localparam logic [63:0] P0001 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] PONES = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_rnd", rnd, 32'h0);
    check_eq("rst_valid", {31'b0, rnd_valid}, 32'h0);
    check_eq("rst_busy", {31'b0, busy}, 32'h0);
    check_eq("rst_fail", {31'b0, hfail}, 32'h0);
    rst_n = 1'b1;

    pulse(0);
    check_eq("gen_busy", {31'b0, busy}, 32'h1);
    feed(P10, 64);
    check_eq("w10_rnd", rnd, 32'hFFFF_FFFF);
    check_eq("w10_valid", {31'b0, rnd_valid}, 32'h1);
    check_eq("w10_busy", {31'b0, busy}, 32'h0);
    check_eq("w10_fail", {31'b0, hfail}, 32'h0);
    pulse(2);
    check_eq("ack_valid", {31'b0, rnd_valid}, 32'h0);
    check_eq("ack_rnd_hold", rnd, 32'hFFFF_FFFF);

    pulse(0);
    feed(P10, 32);
    check_eq("half_busy", {31'b0, busy}, 32'h1);
    pulse(1);
    check_eq("clr_rnd", rnd, 32'h0);
    check_eq("clr_busy", {31'b0, busy}, 32'h0);
    pulse(0);
    feed(P10, 64);
    check_eq("after_clr_rnd", rnd, 32'hFFFF_FFFF);
    check_eq("after_clr_valid", {31'b0, rnd_valid}, 32'h1);
    pulse(2);

    pulse(0);
    feed(P01, 64);
    check_eq("w01_rnd", rnd, 32'h0);
    check_eq("w01_valid", {31'b0, rnd_valid}, 32'h1);
    pulse(2);

    pulse(0);
    feed(P1001, 64);
    check_eq("walt_rnd", rnd, 32'hAAAA_AAAA);
    check_eq("walt_valid", {31'b0, rnd_valid}, 32'h1);
    pulse(2);

    pulse(0);
    feed(PONES, 31);
    check_eq("rct31_fail", {31'b0, hfail}, 32'h0);
    feed(PONES, 1);
    check_eq("rct_fail", {31'b0, hfail}, 32'h1);
    check_eq("rct_valid", {31'b0, rnd_valid}, 32'h0);
    check_eq("rct_rnd", rnd, 32'h0);
    pulse(0);
    check_eq("fail_gen_busy", {31'b0, busy}, 32'h0);
    check_eq("fail_gen_fail", {31'b0, hfail}, 32'h1);
    pulse(1);
    check_eq("rct_clr_fail", {31'b0, hfail}, 32'h0);
    pulse(0);
    check_eq("rct_clr_idle", {31'b0, busy}, 32'h1);
    pulse(1);

    pulse(0);
    feed(P1001, 64);
    check_eq("pre_apt_rnd", rnd, 32'hAAAA_AAAA);
    pulse(2);
    pulse(0);
    feed(P1110, 63);
    check_eq("apt63_fail", {31'b0, hfail}, 32'h0);
    feed(P1110, 1);
    check_eq("apthi_fail", {31'b0, hfail}, 32'h1);
    check_eq("apthi_rnd", rnd, 32'h0);
    check_eq("apthi_busy", {31'b0, busy}, 32'h0);
    pulse(1);

    pulse(0);
    feed(P0001, 64);
    check_eq("aptlo_fail", {31'b0, hfail}, 32'h1);
    pulse(1);

    pulse(3);
    check_eq("genclr_busy", {31'b0, busy}, 32'h0);
    pulse(0);
    feed(P10, 64);
    pulse(2);
    feed(P01, 64);
    pulse(2);
    check_eq("idle_raw_rnd", rnd, 32'hFFFF_FFFF);
    check_eq("idle_raw_valid", {31'b0, rnd_valid}, 32'h0);
    check_eq("idle_raw_busy", {31'b0, busy}, 32'h0);

    pulse(0);
    feed(P10, 20);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_rnd", rnd, 32'h0);
    check_eq("mid_rst_busy", {31'b0, busy}, 32'h0);
    check_eq("mid_rst_valid", {31'b0, rnd_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse(0);
    feed(P01, 64);
    check_eq("post_rst_valid", {31'b0, rnd_valid}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
